sort_drain: RTL

- Downstream consumer of the last insertion-sort cell in the systolic chain.
- Collects one frame of FRAME_LEN signed words from the cell's output FIFO into a local buffer and checks ordering on the fly.
- Then replays the frame, forward or reversed, into the result FIFO and reports a per-frame order-violation count.
- Uses ap_ctrl_chain-style block control, so it slots into the same dataflow region as the cells.

---
 rtl/sort_pkg.sv | 30 +++
 rtl/sort_drain_if.sv | 49 ++++
 rtl/sort_drain_buf.sv | 37 +++
 rtl/sort_drain.sv | 128 ++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// sort_pkg: shared widths, order flags and FSM
// encoding for the insertion-sort chain blocks.
package sort_pkg;

  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 9;
  localparam bit DESCEND   = 1'b0;
  localparam bit REVERSE   = 1'b0;

  typedef logic signed [DATA_W-1:0] word_t;
  typedef logic [CNT_W-1:0]         cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT,
    DONE
  } state_e;

  // Equal neighbours never count as out of order.
  function automatic logic out_of_order(
    input logic  desc,
    input word_t prev,
    input word_t cur
  );
    return desc ? (cur > prev) : (cur < prev);
  endfunction

endpackage

// File: rtl/sort_drain_if.sv
// sort_drain_if: block control, input/output FIFO
// ports and error count of the drain stage.
interface sort_drain_if;
  import sort_pkg::*;

  logic  ap_start;
  logic  ap_continue;
  logic  ap_done;
  logic  ap_idle;
  logic  ap_ready;
  word_t in_V_dout;
  logic  in_V_empty_n;
  logic  in_V_read;
  word_t out_V_din;
  logic  out_V_full_n;
  logic  out_V_write;
  cnt_t  err_cnt;

  modport master (
    output ap_start,
    output ap_continue,
    output in_V_dout,
    output in_V_empty_n,
    output out_V_full_n,
    input  ap_done,
    input  ap_idle,
    input  ap_ready,
    input  in_V_read,
    input  out_V_din,
    input  out_V_write,
    input  err_cnt
  );

  modport slave (
    input  ap_start,
    input  ap_continue,
    input  in_V_dout,
    input  in_V_empty_n,
    input  out_V_full_n,
    output ap_done,
    output ap_idle,
    output ap_ready,
    output in_V_read,
    output out_V_din,
    output out_V_write,
    output err_cnt
  );

endinterface

// File: rtl/sort_drain_buf.sv
// sort_drain_buf: one-frame register array with a
// synchronous write port and a reversible comb read.
module sort_drain_buf
  import sort_pkg::*;
#(
  parameter bit REV = REVERSE
)(
  input  logic  clk,
  input  logic  we_i,
  input  cnt_t  waddr_i,
  input  word_t wdata_i,
  input  cnt_t  raddr_i,
  output word_t rdata_o
);

  localparam int   AW   = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam cnt_t LAST = cnt_t'(FRAME_LEN - 1);

  word_t mem_q [FRAME_LEN];
  cnt_t  ridx;
  logic  unused_hi;

  // Mirror the read index when replaying backwards.
  always_comb begin
    ridx = REV ? (LAST - raddr_i) : raddr_i;
  end

  assign unused_hi = ^{waddr_i[CNT_W-1:AW], ridx[CNT_W-1:AW]};

  // Frame storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[ridx[AW-1:0]];

endmodule

// File: rtl/sort_drain.sv
// sort_drain: collects a frame from the last sort cell,
// counts order violations and replays it downstream.
module sort_drain
  import sort_pkg::*;
#(
  parameter bit DESC_ORD = DESCEND,
  parameter bit REV_ORD  = REVERSE
)(
  input logic         ap_clk,
  input logic         ap_rst,
  sort_drain_if.slave bus
);

  localparam cnt_t LAST = cnt_t'(FRAME_LEN - 1);
  localparam cnt_t SAT  = {CNT_W{1'b1}};

  state_e state_q, state_d;
  cnt_t   wr_idx_q, wr_idx_d;
  cnt_t   rd_idx_q, rd_idx_d;
  cnt_t   run_err_q, run_err_d;
  cnt_t   err_cnt_q, err_cnt_d;
  word_t  prev_q, prev_d;
  logic   first_q, first_d;
  word_t  rd_word;
  logic   pop, push, last_pop, last_push, viol;

  // Handshake qualifiers shared by FSM, datapath and outputs.
  always_comb begin
    pop       = (state_q == COLLECT) && bus.in_V_empty_n;
    push      = (state_q == EMIT) && bus.out_V_full_n;
    last_pop  = pop && (wr_idx_q == LAST);
    last_push = push && (rd_idx_q == LAST);
    viol      = pop && !first_q &&
                out_of_order(DESC_ORD, prev_q, bus.in_V_dout);
  end

  sort_drain_buf #(
    .REV (REV_ORD)
  ) u_buf (
    .clk     (ap_clk),
    .we_i    (pop),
    .waddr_i (wr_idx_q),
    .wdata_i (bus.in_V_dout),
    .raddr_i (rd_idx_q),
    .rdata_o (rd_word)
  );

  // State register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is only sampled in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.ap_start)    state_d = COLLECT;
      COLLECT: if (last_pop)        state_d = EMIT;
      EMIT:    if (last_push)       state_d = DONE;
      DONE:    if (bus.ap_continue) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Strobes and data out, all decoded from current state.
  always_comb begin
    bus.ap_idle     = 1'b0;
    bus.ap_done     = 1'b0;
    bus.ap_ready    = last_pop;
    bus.in_V_read   = pop;
    bus.out_V_write = push;
    bus.out_V_din   = '0;
    unique case (state_q)
      IDLE:    bus.ap_idle   = 1'b1;
      EMIT:    bus.out_V_din = rd_word;
      DONE:    bus.ap_done   = 1'b1;
      default: ;
    endcase
  end

  assign bus.err_cnt = err_cnt_q;

  // Counter, checker and reported-count next values.
  always_comb begin
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    run_err_d = run_err_q;
    err_cnt_d = err_cnt_q;
    prev_d    = prev_q;
    first_d   = first_q;
    if (state_q == IDLE && bus.ap_start) begin
      run_err_d = '0;
      first_d   = 1'b1;
    end
    if (pop) begin
      prev_d   = bus.in_V_dout;
      first_d  = 1'b0;
      wr_idx_d = last_pop ? '0 : wr_idx_q + 1'b1;
      if (viol && run_err_q != SAT)
        run_err_d = run_err_q + 1'b1;
    end
    if (push) begin
      rd_idx_d = last_push ? '0 : rd_idx_q + 1'b1;
      if (last_push) err_cnt_d = run_err_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      run_err_q <= '0;
      err_cnt_q <= '0;
      prev_q    <= '0;
      first_q   <= 1'b1;
    end else begin
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      run_err_q <= run_err_d;
      err_cnt_q <= err_cnt_d;
      prev_q    <= prev_d;
      first_q   <= first_d;
    end
  end

endmodule
